// File: rtl/trace_checker.sv
// Trace checker: compares retiring write-back events against a FIFO of golden trace entries.
// It reports the first mismatch or underflow, or a pass once the golden trace has been fully consumed.
module trace_checker #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_we,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        gold_valid,
  output logic        gold_ready,
  input  logic [31:0] gold_pc,
  input  logic [4:0]  gold_wnum,
  input  logic [31:0] gold_wdata,
  input  logic        trace_end,
  output logic        chk_done,
  output logic        chk_pass,
  output logic        chk_error,
  output logic [1:0]  err_code,
  output logic [31:0] err_pc,
  output logic [31:0] err_exp_wdata,
  output logic [31:0] err_got_wdata,
  output logic [31:0] match_cnt
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, ERROR, PASS} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [4:0]    fifo_wnum  [FIFO_DEPTH];
  logic [31:0]   fifo_wdata [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          end_flag;

  logic          active, empty, full, evt, act_evt, push, pop;
  logic          pc_bad, data_bad, underflow, mismatch, matched;
  logic [31:0]   head_pc, head_wdata;
  logic [4:0]    head_wnum;
  logic [1:0]    code_nxt;

  always_comb begin
    active     = (state == IDLE) || (state == RUN);
    empty      = (count == '0);
    full       = (count == CW'(FIFO_DEPTH));
    gold_ready = resetn && active && !full;
    evt        = (debug_wb_rf_we != 4'b0000) && (debug_wb_rf_wnum != 5'd0);
    act_evt    = active && evt;
    push       = gold_valid && gold_ready;
    head_pc    = fifo_pc[rd_ptr];
    head_wnum  = fifo_wnum[rd_ptr];
    head_wdata = fifo_wdata[rd_ptr];
    pc_bad     = (head_pc != debug_wb_pc);
    data_bad   = (head_wnum != debug_wb_rf_wnum);
    for (int unsigned i = 0; i < 4; i++) begin
      if (debug_wb_rf_we[i] && (head_wdata[8*i +: 8] != debug_wb_rf_wdata[8*i +: 8]))
        data_bad = 1'b1;
    end
    // Underflow is judged on registered occupancy, so a same-cycle push never bypasses.
    underflow  = act_evt && empty;
    mismatch   = act_evt && !empty && (pc_bad || data_bad);
    matched    = act_evt && !empty && !pc_bad && !data_bad;
    pop        = act_evt && !empty;
    code_nxt   = underflow ? 2'b11 : (pc_bad ? 2'b01 : 2'b10);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (underflow || mismatch) state_nxt = ERROR;
        else if (evt || push)      state_nxt = RUN;
      end
      RUN: begin
        if (underflow || mismatch)                 state_nxt = ERROR;
        else if (end_flag && empty && !evt && !push) state_nxt = PASS;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= gold_pc;
      fifo_wnum[wr_ptr]  <= gold_wnum;
      fifo_wdata[wr_ptr] <= gold_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      end_flag      <= 1'b0;
      err_code      <= 2'b00;
      err_pc        <= '0;
      err_exp_wdata <= '0;
      err_got_wdata <= '0;
      match_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (trace_end) end_flag <= 1'b1;
      if (underflow || mismatch) begin
        err_code      <= code_nxt;
        err_pc        <= debug_wb_pc;
        err_exp_wdata <= underflow ? '0 : head_wdata;
        err_got_wdata <= debug_wb_rf_wdata;
      end
      if (matched && (match_cnt != '1)) match_cnt <= match_cnt + 32'd1;
    end
  end

  assign chk_done  = (state == ERROR) || (state == PASS);
  assign chk_pass  = (state == PASS);
  assign chk_error = (state == ERROR);

endmodule

// File: tb/tb_trace_checker.sv
// Self-checking bench for trace_checker: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_trace_checker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_pc;
  logic [4:0]  gold_wnum;
  logic [31:0] gold_wdata;
  logic        trace_end;
  logic        chk_done, chk_pass, chk_error;
  logic [1:0]  err_code;
  logic [31:0] err_pc, err_exp_wdata, err_got_wdata, match_cnt;

  trace_checker #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .gold_valid(gold_valid), .gold_ready(gold_ready),
    .gold_pc(gold_pc), .gold_wnum(gold_wnum), .gold_wdata(gold_wdata),
    .trace_end(trace_end),
    .chk_done(chk_done), .chk_pass(chk_pass), .chk_error(chk_error),
    .err_code(err_code), .err_pc(err_pc), .err_exp_wdata(err_exp_wdata),
    .err_got_wdata(err_got_wdata), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;

  // Reference model: golden queue plus verdict flags.
  entry_t      mq[$];
  bit          m_started, m_end, m_done, m_pass;
  logic [1:0]  m_code;
  logic [31:0] m_epc, m_eexp, m_egot, m_cnt;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic bit exp_ready();
    return resetn && !m_done && (mq.size() < DEPTH);
  endfunction

  task automatic model_update();
    entry_t      h;
    bit          ev, rdy, err, pushed, was_empty;
    logic [31:0] mask;
    if (!resetn) begin
      mq.delete();
      m_started = 0; m_end = 0; m_done = 0; m_pass = 0;
      m_code = 2'b00; m_epc = '0; m_eexp = '0; m_egot = '0; m_cnt = '0;
      return;
    end
    if (m_done) return;
    rdy       = mq.size() < DEPTH;
    was_empty = (mq.size() == 0);
    ev        = (debug_wb_rf_we != 0) && (debug_wb_rf_wnum != 0);
    err       = 0;
    if (ev) begin
      if (was_empty) begin
        err = 1; m_code = 2'b11; m_eexp = '0;
      end else begin
        h    = mq[0];
        mask = {{8{debug_wb_rf_we[3]}}, {8{debug_wb_rf_we[2]}},
                {8{debug_wb_rf_we[1]}}, {8{debug_wb_rf_we[0]}}};
        if (h.pc != debug_wb_pc) begin
          err = 1; m_code = 2'b01;
        end else if (h.wnum != debug_wb_rf_wnum ||
                     ((h.wdata ^ debug_wb_rf_wdata) & mask) != 0) begin
          err = 1; m_code = 2'b10;
        end
        if (err) m_eexp = h.wdata;
        else begin
          void'(mq.pop_front());
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
      end
      if (err) begin
        m_epc = debug_wb_pc; m_egot = debug_wb_rf_wdata; m_done = 1;
      end
    end
    pushed = gold_valid && rdy;
    if (!err && pushed) mq.push_back('{gold_pc, gold_wnum, gold_wdata});
    if (!err && m_started && m_end && was_empty && !ev && !pushed) begin
      m_done = 1; m_pass = 1;
    end
    if (ev || pushed) m_started = 1;
    if (trace_end) m_end = 1;
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("gold_ready", 32'(gold_ready), 32'(exp_ready()));
    model_update();
    @(posedge clk);
    #1;
    chk("chk_done",  32'(chk_done),  32'(m_done));
    chk("chk_pass",  32'(chk_pass),  32'(m_pass));
    chk("chk_error", 32'(chk_error), 32'(m_done && !m_pass));
    chk("err_code",  32'(err_code),  32'(m_code));
    chk("err_pc",    err_pc,        m_epc);
    chk("err_exp",   err_exp_wdata, m_eexp);
    chk("err_got",   err_got_wdata, m_egot);
    chk("match_cnt", match_cnt,     m_cnt);
  endtask

  task automatic clear_inputs();
    debug_wb_pc = '0; debug_wb_rf_we = '0; debug_wb_rf_wnum = '0; debug_wb_rf_wdata = '0;
    gold_valid = 0; gold_pc = '0; gold_wnum = '0; gold_wdata = '0; trace_end = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    cycle();
    cycle();
    resetn = 1;
  endtask

  task automatic push1(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
    gold_valid = 1; gold_pc = pc; gold_wnum = wn; gold_wdata = wd;
    cycle();
    gold_valid = 0;
  endtask

  task automatic event1(input logic [31:0] pc, input logic [3:0] we,
                        input logic [4:0] wn, input logic [31:0] wd);
    debug_wb_pc = pc; debug_wb_rf_we = we; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
    cycle();
    debug_wb_rf_we = '0; debug_wb_rf_wnum = '0;
  endtask

  initial begin
    entry_t      h;
    logic [3:0]  we;
    logic [31:0] keep;
    clear_inputs();
    resetn = 0;

    // Two matching events then trace_end -> pass with two matches.
    do_reset();
    push1(32'h1c00_0000, 5'd1, 32'h0000_0005);
    push1(32'h1c00_0004, 5'd2, 32'h0000_000A);
    event1(32'h1c00_0000, 4'hF, 5'd1, 32'h0000_0005);
    event1(32'h1c00_0004, 4'hF, 5'd2, 32'h0000_000A);
    trace_end = 1; cycle(); trace_end = 0;
    cycle();
    chk("pass_flag", 32'(chk_pass), 32'd1);
    chk("pass_cnt", match_cnt, 32'd2);

    // PC mismatch.
    do_reset();
    push1(32'h1c00_0000, 5'd1, 32'h0000_0005);
    event1(32'h1c00_0008, 4'hF, 5'd1, 32'h0000_0005);
    chk("pcerr_flag", 32'(chk_error), 32'd1);
    chk("pcerr_code", 32'(err_code), 32'd1);
    chk("pcerr_pc", err_pc, 32'h1c00_0008);
    chk("pcerr_exp", err_exp_wdata, 32'h0000_0005);

    // Byte-masked data compare.
    do_reset();
    push1(32'h1c00_0000, 5'd1, 32'h1234_5678);
    push1(32'h1c00_0000, 5'd1, 32'h1234_5678);
    event1(32'h1c00_0000, 4'b0001, 5'd1, 32'hFFFF_FF78);
    chk("mask_cnt", match_cnt, 32'd1);
    event1(32'h1c00_0000, 4'b1111, 5'd1, 32'hFFFF_FF78);
    chk("data_code", 32'(err_code), 32'd2);
    chk("data_got", err_got_wdata, 32'hFFFF_FF78);

    // Ignored non-events, then underflow despite a simultaneous push.
    do_reset();
    event1(32'h1c00_0000, 4'hF, 5'd0, 32'h1);
    event1(32'h1c00_0000, 4'h0, 5'd3, 32'h1);
    chk("ignored_err", 32'(chk_error), 32'd0);
    gold_valid = 1; gold_pc = 32'h1c00_0000; gold_wnum = 5'd3; gold_wdata = 32'h9;
    event1(32'h1c00_0000, 4'hF, 5'd3, 32'h9);
    gold_valid = 0;
    chk("uflow_code", 32'(err_code), 32'd3);
    chk("uflow_exp", err_exp_wdata, 32'd0);

    // FIFO fill, single pop frees one slot, reset mid-stream.
    do_reset();
    gold_valid = 1; gold_pc = 32'h1c00_0010; gold_wnum = 5'd4; gold_wdata = 32'hCAFE_0001;
    for (int i = 0; i < DEPTH + 2; i++) cycle();
    gold_valid = 0;
    #1 chk("full_ready", 32'(gold_ready), 32'd0);
    event1(32'h1c00_0010, 4'hF, 5'd4, 32'hCAFE_0001);
    #1 chk("freed_ready", 32'(gold_ready), 32'd1);
    resetn = 0; cycle(); resetn = 1;
    chk("rst_cnt", match_cnt, 32'd0);
    cycle();

    // Randomized episodes.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        clear_inputs();
        if (c < 55) begin
          gold_valid = ($urandom % 2) == 1;
          gold_pc    = 32'h1c00_0000 + 4 * ($urandom % 16);
          gold_wnum  = 5'($urandom_range(0, 31));
          gold_wdata = $urandom;
        end
        if (c == 60) trace_end = 1;
        if (($urandom % 100) < 45) begin
          if (mq.size() > 0 && (($urandom % 100) < (ep < 4 ? 95 : 80))) begin
            h    = mq[0];
            we   = 4'($urandom_range(1, 15));
            keep = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
            debug_wb_pc       = h.pc;
            debug_wb_rf_we    = we;
            debug_wb_rf_wnum  = h.wnum;
            debug_wb_rf_wdata = (h.wdata & keep) | ($urandom & ~keep);
          end else begin
            debug_wb_pc       = 32'h1c00_0000 + 4 * ($urandom % 16);
            debug_wb_rf_we    = 4'($urandom);
            debug_wb_rf_wnum  = 5'($urandom);
            debug_wb_rf_wdata = $urandom;
          end
        end
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning golden-entry FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port debug_wb_pc  input  32  PC of instruction retiring in WB.
REQ-005 SHALL have port debug_wb_rf_we  input  4  per-byte register-file write enable from WB.
REQ-006 SHALL have port debug_wb_rf_wnum  input  5  destination register number.
REQ-007 SHALL have port debug_wb_rf_wdata  input  32  register write data.
REQ-008 SHALL have port gold_valid  input  1  golden entry offered.
REQ-009 SHALL have port gold_ready  output  1  checker accepts golden entry.
REQ-010 SHALL have port gold_pc  input  32, gold_wnum  input  5, gold_wdata  input  32  expected trace entry.
REQ-011 SHALL have port trace_end  input  1  pulse: no further golden entries will be pushed.
REQ-012 SHALL have port chk_done  output  1, chk_pass  output  1, chk_error  output  1  status.
REQ-013 SHALL have port err_code  output  2  00 none, 01 PC mismatch, 10 wnum/data mismatch, 11 underflow.
REQ-014 SHALL have port err_pc, err_exp_wdata, err_got_wdata  output  32 each  captured failure context.
REQ-015 SHALL have port match_cnt  output  32  number of matched events.

Function
REQ-016 A trace event SHALL be a cycle with debug_wb_rf_we != 4'b0000 and debug_wb_rf_wnum != 0; other cycles SHALL be ignored.
REQ-017 Golden FIFO push SHALL occur when gold_valid && gold_ready; gold_ready SHALL equal !full, combinational from registered occupancy only (a same-cycle pop never frees space for a same-cycle push).
REQ-018 FIFO pop SHALL occur on each trace event in state RUN with FIFO non-empty; read/write pointers wrap modulo FIFO_DEPTH; occupancy counter FIFO_DEPTH+1 values wide.
REQ-019 No bypass: an event arriving while FIFO empty SHALL be an underflow even if a push occurs the same cycle.
REQ-020 Comparison order: gold_pc vs debug_wb_pc first (mismatch -> code 01); else wnum equality and wdata equality on bytes whose we bit is 1 (mismatch -> code 10).
REQ-021 States: IDLE, RUN, ERROR, PASS; chk_done=1 in ERROR or PASS; chk_pass=1 only in PASS; chk_error=1 only in ERROR.
REQ-022 IDLE->RUN on first push or first event; an event in IDLE SHALL be evaluated as in RUN (same cycle transition).
REQ-023 RUN->ERROR on mismatch or underflow; err_code, err_pc=debug_wb_pc, err_exp_wdata=head gold_wdata (0 on underflow), err_got_wdata=debug_wb_rf_wdata captured same edge.
REQ-024 trace_end SHALL be latched in an end flag; RUN->PASS when end flag set, FIFO empty, and no event this cycle.
REQ-025 ERROR and PASS SHALL be terminal until reset; in them gold_ready=0, events ignored, match_cnt and err_* frozen.
REQ-026 match_cnt SHALL increment by 1 per matched event, saturating at 32'hFFFFFFFF.
REQ-027 All status/err/match outputs SHALL be registered; visible the cycle after the deciding event (latency 1).
REQ-028 Event and trace_end in the same cycle: event evaluated first; PASS not entered that cycle.

Reset
REQ-029 resetn=0 at a clock edge SHALL force state IDLE, FIFO empty, end flag 0, match_cnt=0, err_code=00, err_pc/err_exp_wdata/err_got_wdata=0, chk_done/chk_pass/chk_error=0.
REQ-030 gold_ready SHALL be 0 while resetn=0 and 1 in the first cycle after release.
REQ-031 Reset mid-operation SHALL discard all FIFO contents and latched errors with no partial effect.

Verification
REQ-032 Push {1c000000,r1,00000005},{1c000004,r2,0000000A}; matching events; trace_end -> chk_pass=1, match_cnt=2.
REQ-033 Push {1c000000,r1,00000005}; event pc 1c000008 -> next cycle chk_error=1, err_code=01, err_pc=1c000008, err_exp_wdata=00000005.
REQ-034 Push wdata 12345678; event we=0001, wdata FFFFFF78 -> match; event we=1111 same data against 12345678 -> err_code=10, err_got_wdata=FFFFFF78.
REQ-035 FIFO empty, event with wnum=3 plus simultaneous push -> err_code=11, err_exp_wdata=0; event with wnum=0 or we=0 -> ignored, no error.
REQ-036 gold_valid held high, no events -> exactly FIFO_DEPTH (4) pushes then gold_ready=0; one event pops, gold_ready=1 next cycle; resetn=0 mid-stream -> all outputs reset values, gold_ready=1 after release.
